// File: rtl/disp_ingredientes_if.sv
// Handshake and output bundle between the beverage-selection FSM and the
// multi-channel ingredient dispenser.
interface disp_ingredientes_if #(
  parameter int N_CH   = 3,
  parameter int DOSE_W = 3
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                     start;
  logic [N_CH*DOSE_W-1:0]   dosis;
  logic                     abort;
  logic                     busy;
  logic [N_CH-1:0]          led;
  logic [CH_W-1:0]          canal;
  logic                     done;
  logic                     abortado;

  modport master (
    output start, dosis, abort,
    input  busy, led, canal, done, abortado
  );

  modport slave (
    input  start, dosis, abort,
    output busy, led, canal, done, abortado
  );
endinterface

// File: rtl/disp_ingredientes.sv
// Sequential N-channel ingredient dispenser: walks the channels in order and
// pulses each channel's output once per requested dose, with abort support.
module disp_ingredientes #(
  parameter int N_CH      = 3,
  parameter int DOSE_W    = 3,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  disp_ingredientes_if.slave bus
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_POUR,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t              state_reg;
  logic [CH_W-1:0]     ch_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;
  logic [N_CH-1:0]     led_reg;
  logic                done_reg;
  logic                abortado_reg;
  logic [DOSE_W-1:0]   rem_reg  [N_CH];
  logic [DOSE_W-1:0]   dosis_ch [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign dosis_ch[gi] = bus.dosis[gi*DOSE_W +: DOSE_W];
  end

  wire abort_live = bus.abort &&
                    (state_reg == ST_SEL || state_reg == ST_POUR || state_reg == ST_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ch_reg       <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      led_reg      <= '0;
      done_reg     <= 1'b0;
      abortado_reg <= 1'b0;
      for (int i = 0; i < N_CH; i++) rem_reg[i] <= '0;
    end else begin
      done_reg     <= 1'b0;
      abortado_reg <= 1'b0;
      if (abort_live) begin
        // Abort wins over any pending transition and kills the output now.
        state_reg    <= ST_FIN;
        led_reg      <= '0;
        done_reg     <= 1'b1;
        abortado_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.start) begin
              for (int i = 0; i < N_CH; i++) rem_reg[i] <= dosis_ch[i];
              ch_reg    <= '0;
              busy_reg  <= 1'b1;
              state_reg <= ST_SEL;
            end
          end
          ST_SEL: begin
            if (rem_reg[ch_reg] != '0) begin
              state_reg <= ST_POUR;
              cnt_reg   <= CNT_W'(PULSE_CYC);
              led_reg   <= N_CH'(1) << ch_reg;
            end else if (ch_reg != LAST_CH) begin
              ch_reg <= ch_reg + 1'b1;
            end else begin
              state_reg <= ST_FIN;
              done_reg  <= 1'b1;
            end
          end
          ST_POUR: begin
            if (cnt_reg == CNT_W'(1)) begin
              led_reg          <= '0;
              rem_reg[ch_reg]  <= rem_reg[ch_reg] - 1'b1;
              cnt_reg          <= CNT_W'(GAP_CYC);
              state_reg        <= ST_GAP;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt_reg == CNT_W'(1)) state_reg <= ST_SEL;
            else                      cnt_reg   <= cnt_reg - 1'b1;
          end
          ST_FIN: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            ch_reg    <= '0;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.led      = led_reg;
  assign bus.canal    = ch_reg;
  assign bus.done     = done_reg;
  assign bus.abortado = abortado_reg;
endmodule

// File: tb/tb_disp_ingredientes.sv
// Scoreboard bench for disp_ingredientes: stimulus pushes the expected sequence
// summary, a negedge monitor measures the outputs and compares on each done.
module tb_disp_ingredientes;
  localparam int N_CH   = 3;
  localparam int DOSE_W = 3;
  localparam int PULSE  = 4;
  localparam int GAP    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_ingredientes_if #(.N_CH(N_CH), .DOSE_W(DOSE_W)) bus ();

  disp_ingredientes #(
    .N_CH(N_CH), .DOSE_W(DOSE_W), .PULSE_CYC(PULSE), .GAP_CYC(GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int              done_rel;
    int              abrt;
    int              led_cyc;
    int              first_led;
    logic [N_CH*8-1:0] pulses;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  int                led_cyc_m, first_led_m, run_len, gap_len;
  int                last_ch;
  logic [N_CH*8-1:0] pulses_m;
  logic [N_CH-1:0]   led_prev;
  bit                after_done;

  task automatic clear_acc();
    led_cyc_m   = 0;
    first_led_m = -1;
    run_len     = 0;
    gap_len     = 0;
    last_ch     = -1;
    pulses_m    = '0;
    led_prev    = '0;
  endtask

  initial clear_acc();

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      clear_acc();
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        check("busy_after_done", int'(bus.busy), 0);
        check("done_single", int'(bus.done), 0);
        after_done = 1'b0;
      end
      if (bus.led != '0) begin
        led_cyc_m++;
        run_len++;
        if (first_led_m < 0) first_led_m = cyc - start_cyc;
        check("led_matches_canal", int'(bus.led), 1 << bus.canal);
        if (led_prev == '0) begin
          if (gap_len > 0 && int'(bus.canal) == last_ch)
            check("low_between_doses", gap_len, GAP + 1);
          gap_len = 0;
        end
        for (int i = 0; i < N_CH; i++)
          if (bus.led[i] && !led_prev[i]) pulses_m[i*8 +: 8] = pulses_m[i*8 +: 8] + 8'd1;
      end else if (led_prev != '0) begin
        if (!bus.done) check("pulse_len", run_len, PULSE);
        run_len = 0;
        gap_len = 1;
        last_ch = int'(bus.canal);
      end else if (gap_len > 0) begin
        gap_len++;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc - start_cyc, e.done_rel);
          check("abortado", int'(bus.abortado), e.abrt);
          check("busy_in_fin", int'(bus.busy), 1);
          check("led_high_cycles", led_cyc_m, e.led_cyc);
          check("first_led_cycle", first_led_m, e.first_led);
          check("pulse_counts", int'(pulses_m), int'(e.pulses));
        end
        after_done = 1'b1;
        clear_acc();
      end else begin
        led_prev = bus.led;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_seq(input logic [N_CH*DOSE_W-1:0] d, input int done_rel,
                         input int abrt, input int led_cyc, input int first_led,
                         input logic [N_CH*8-1:0] pulses,
                         input int abort_at, input int restart_at);
    exp_t e;
    int   n;
    int   rel;
    e.done_rel = done_rel; e.abrt = abrt; e.led_cyc = led_cyc;
    e.first_led = first_led; e.pulses = pulses;
    @(posedge clk); #1;
    start_cyc = cyc;
    exp_q.push_back(e);
    bus.dosis = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dosis = ~d;
    n = 0;
    while (!bus.done && n < 200) begin
      rel = cyc - start_cyc;
      if (rel == abort_at) bus.abort = 1'b1;
      if (rel == restart_at) begin bus.start = 1'b1; bus.dosis = '1; end
      @(posedge clk); #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      n++;
      if (abort_at >= 0 && cyc - start_cyc == abort_at + 1) begin
        check("abort_led_off", int'(bus.led), 0);
        check("abort_done", int'(bus.done), 1);
      end
    end
    if (!bus.done) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dosis = '0;
    bus.abort = 1'b0;
    #2;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_led", int'(bus.led), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_canal", int'(bus.canal), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a dose
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.dosis = {3'd0, 3'd0, 3'd3};
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_led", int'(bus.led), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_led", int'(bus.led), 0);
    check("mid_reset_busy", int'(bus.busy), 0);
    check("mid_reset_canal", int'(bus.canal), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Abort while idle is ignored
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("idle_abort_busy", int'(bus.busy), 0);
    check("idle_abort_done", int'(bus.done), 0);

    //       dosis {ch2,ch1,ch0}        done abrt cyc first pulses{ch2,ch1,ch0}  abort restart
    run_seq({3'd2, 3'd0, 3'd1},          25,  0,  12,  2, {8'd2, 8'd0, 8'd1},  -1, -1);
    run_seq({3'd0, 3'd0, 3'd0},           4,  0,   0, -1, {8'd0, 8'd0, 8'd0},  -1, -1);
    run_seq({3'd0, 3'd7, 3'd0},          53,  0,  28,  3, {8'd0, 8'd7, 8'd0},  -1, -1);
    run_seq({3'd2, 3'd0, 3'd1},          20,  1,  10,  2, {8'd2, 8'd0, 8'd1},  19, -1);
    run_seq({3'd1, 3'd2, 3'd0},          25,  0,  12,  3, {8'd1, 8'd2, 8'd0},  -1, -1);
    run_seq({3'd0, 3'd1, 3'd2},          25,  0,  12,  2, {8'd0, 8'd1, 8'd2},  -1,  5);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_busy", int'(bus.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
